// File: rtl/univ_shift_engine.sv
// Multi-cycle universal shift engine: accepts a command over a valid/ready handshake,
// then performs one shift/rotate step per clock until the requested distance is covered.
module univ_shift_engine #(
  parameter int N  = 16,
  parameter int AW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    op,
  input  logic [AW-1:0] amt,
  input  logic [N-1:0]  data_in,
  input  logic          sin,
  input  logic          abort,
  output logic [N-1:0]  data_out,
  output logic          sout,
  output logic          busy,
  output logic          done,
  output logic          o_dbg_state
);

  // Handshake: a command is taken on any rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and nothing is queued while it is low.

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_SHR  = 3'd3;
  localparam logic [2:0] OP_SRA  = 3'd4;
  localparam logic [2:0] OP_ROL  = 3'd5;
  localparam logic [2:0] OP_ROR  = 3'd6;
  localparam logic [2:0] OP_SIN  = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic [2:0]    r_op;
  logic [AW-1:0] r_cnt;
  logic [N-1:0]  r_data;
  logic          r_sout;
  logic          r_done;

  logic [AW-1:0] w_amt;
  logic [N-1:0]  w_step_data;
  logic          w_step_sout;

  assign w_amt = (amt > AW'(N)) ? AW'(N) : amt;

  always_comb begin
    w_step_data = r_data;
    w_step_sout = r_sout;
    case (r_op)
      OP_SHL: begin
        w_step_data = {r_data[N-2:0], 1'b0};
        w_step_sout = r_data[N-1];
      end
      OP_SHR: begin
        w_step_data = {1'b0, r_data[N-1:1]};
        w_step_sout = r_data[0];
      end
      OP_SRA: begin
        w_step_data = {r_data[N-1], r_data[N-1:1]};
        w_step_sout = r_data[0];
      end
      OP_ROL: begin
        w_step_data = {r_data[N-2:0], r_data[N-1]};
        w_step_sout = r_data[N-1];
      end
      OP_ROR: begin
        w_step_data = {r_data[0], r_data[N-1:1]};
        w_step_sout = r_data[0];
      end
      OP_SIN: begin
        w_step_data = {r_data[N-2:0], sin};
        w_step_sout = r_data[N-1];
      end
      default: begin
        w_step_data = r_data;
        w_step_sout = r_sout;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_HOLD;
      r_cnt   <= '0;
      r_data  <= '0;
      r_sout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op <= op;
            if (op == OP_HOLD) begin
              r_done <= 1'b1;
            end else if (op == OP_LOAD) begin
              r_data <= data_in;
              r_done <= 1'b1;
            end else if (w_amt == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_cnt   <= w_amt;
            end
          end
        end
        S_RUN: begin
          // Abort leaves the partially shifted value in place and suppresses done.
          if (abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_data <= w_step_data;
            r_sout <= w_step_sout;
            r_cnt  <= r_cnt - AW'(1);
            if (r_cnt == AW'(1)) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state == S_RUN);
  assign done        = r_done;
  assign data_out    = r_data;
  assign sout        = r_sout;
  assign o_dbg_state = r_state;

endmodule
